imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined core: owns the program counter, drives the combinational instruction-memory read address, and loads the IF/ID pipeline register. Applies hazard-unit stalls (load-use), branch redirects with a one-bubble flush, and halts fetch cleanly past the last program word. Sits between the instruction memory and the decode stage; hazard unit and branch comparator drive its control inputs.

---
 rtl/imem_fetch_ctrl.sv | 90 +++++++++
 tb/tb_imem_fetch_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the imem read address
// and loads the IF/ID register with stall, branch-flush and end-of-program halt.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_MAX   = 32'd48,
    parameter logic [31:0] NOP      = 32'h00000013,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] tgt;

    assign tgt       = branch_target & ~32'h3;
    assign imem_addr = pc;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ifid_pc     <= 32'd0;
            ifid_instr  <= NOP;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_RUN;
                end
                S_RUN: begin
                    if (branch_taken) begin
                        pc         <= tgt;
                        ifid_pc    <= 32'd0;
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                    end else if (stall) begin
                        state <= S_RUN;
                    end else if (pc > PC_MAX) begin
                        ifid_instr <= NOP;
                        ifid_valid <= 1'b0;
                        state      <= S_HALT;
                    end else begin
                        ifid_instr <= imem_instr;
                        ifid_pc    <= pc;
                        ifid_valid <= 1'b1;
                        pc         <= pc + 32'd4;
                        if (fetch_count != {CNT_W{1'b1}})
                            fetch_count <= fetch_count + CNT_ONE;
                    end
                end
                S_HALT: begin
                    // A late branch from an older instruction can revive fetch
                    if (branch_taken) begin
                        pc <= tgt;
                        if (tgt <= PC_MAX)
                            state <= S_RUN;
                    end else if (start) begin
                        pc          <= RESET_PC;
                        fetch_count <= '0;
                        state       <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios followed by
// randomized control inputs, all compared against a behavioural model.
module tb_imem_fetch_ctrl;

    localparam logic [31:0] PC_MAX = 32'd48;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int passed = 0;
    int total  = 0;

    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic [15:0] saved_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[7:0], 8'h5A, a[15:0]};
    endfunction

    assign imem_instr = mem_word(imem_addr);

    imem_fetch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 32'd0;
        m_ipc   = 32'd0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_cnt   = 16'd0;
    endtask

    task automatic model_edge(input logic st, input logic stl,
                              input logic bt, input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (m_mode == M_IDLE) begin
            if (st) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (bt) begin
                m_pc = t; m_ipc = 0; m_instr = NOP; m_valid = 0;
            end else if (!stl) begin
                if (m_pc > PC_MAX) begin
                    m_instr = NOP; m_valid = 0; m_mode = M_HALT;
                end else begin
                    m_instr = mem_word(m_pc); m_ipc = m_pc; m_valid = 1;
                    m_pc = m_pc + 4;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
                end
            end
        end else begin
            if (bt) begin
                m_pc = t;
                if (t <= PC_MAX) m_mode = M_RUN;
            end else if (st) begin
                m_pc = 0; m_cnt = 0; m_mode = M_RUN;
            end
        end
    endtask

    task automatic chk_all();
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
        chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt});
        if (m_valid) chk("ifid_pc", ifid_pc, m_ipc);
    endtask

    task automatic cyc(input logic st, input logic stl,
                       input logic bt, input logic [31:0] tgt);
        start = st; stall = stl; branch_taken = bt; branch_target = tgt;
        @(posedge clk);
        if (!reset) model_edge(st, stl, bt, tgt);
        #1;
        chk_all();
    endtask

    initial begin
        reset = 1'b1; start = 0; stall = 0; branch_taken = 0;
        branch_target = 0;
        model_reset();
        #1;
        chk_all();
        chk("rst_ifid_pc", ifid_pc, 32'd0);
        cyc(0, 0, 0, 0);
        #3 reset = 1'b0;

        // IDLE ignores everything except start
        cyc(0, 1, 1, 32'd20);
        cyc(0, 0, 1, 32'd8);
        chk("idle_addr", imem_addr, 32'd0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 40 && !halted; i++) cyc(0, 0, 0, 0);
        chk("first_halt", {31'd0, halted}, 32'd1);
        chk("first_count", {16'd0, fetch_count}, 32'd13);

        // Restart, then stall while 8 sits in IF/ID
        cyc(1, 0, 0, 0);
        chk("restart_cnt", {16'd0, fetch_count}, 32'd0);
        for (int i = 0; i < 10 && !(ifid_valid && ifid_pc == 8); i++)
            cyc(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0);
            chk("stall_ipc", ifid_pc, 32'd8);
            chk("stall_addr", imem_addr, 32'd12);
            chk("stall_cnt", {16'd0, fetch_count}, 32'd3);
        end
        cyc(0, 0, 0, 0);
        chk("post_stall", ifid_pc, 32'd12);

        // Branch with unaligned target and a simultaneous stall
        for (int i = 0; i < 10 && imem_addr != 20; i++) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h1B);
        chk("br_valid", {31'd0, ifid_valid}, 32'd0);
        chk("br_instr", ifid_instr, NOP);
        chk("br_ipc", ifid_pc, 32'd0);
        chk("br_addr", imem_addr, 32'd24);
        cyc(0, 0, 0, 0);
        chk("br_tgt_ipc", ifid_pc, 32'd24);

        // Revive from HALT with an in-range branch
        for (int i = 0; i < 40 && !halted; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'd36);
        chk("hb_run", {31'd0, halted}, 32'd0);
        cyc(0, 0, 0, 0);
        chk("hb_ipc0", ifid_pc, 32'd36);
        cyc(0, 0, 0, 0);
        chk("hb_ipc1", ifid_pc, 32'd40);

        // Out-of-range branch keeps HALT; branch beats start
        for (int i = 0; i < 40 && !halted; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'd100);
        chk("hb_far_halt", {31'd0, halted}, 32'd1);
        chk("hb_far_addr", imem_addr, 32'd100);
        saved_cnt = fetch_count;
        cyc(1, 0, 1, 32'd100);
        chk("bs_halt", {31'd0, halted}, 32'd1);
        chk("bs_cnt", {16'd0, fetch_count}, {16'd0, saved_cnt});
        cyc(1, 0, 0, 0);
        chk("hs_addr", imem_addr, 32'd0);
        chk("hs_cnt", {16'd0, fetch_count}, 32'd0);
        chk("hs_run", {31'd0, halted}, 32'd0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 20 && imem_addr != 28; i++) cyc(0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_all();
        cyc(0, 0, 0, 0);
        #3 reset = 1'b0;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 32'd12);
        chk("rst_nofetch", {31'd0, ifid_valid}, 32'd0);

        // Randomized control traffic
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 120));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
